// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, widths and response-slot state type.
package alu_pkg;

    localparam int ALU_CTRL_W = 3;
    localparam int ALU_LEN    = 32;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and shared-ALU signals of alu_arbiter.
// slave is the arbiter's view; master is the surrounding core (requesters, consumer, ALU).
interface alu_arbiter_if #(parameter int LEN = alu_pkg::ALU_LEN);
    import alu_pkg::*;

    logic                  req0_valid;
    logic                  req0_ready;
    logic [LEN-1:0]        req0_op1;
    logic [LEN-1:0]        req0_op2;
    logic [ALU_CTRL_W-1:0] req0_ctrl;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [LEN-1:0]        req1_op1;
    logic [LEN-1:0]        req1_op2;
    logic [ALU_CTRL_W-1:0] req1_ctrl;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [LEN-1:0]        rsp_result;
    logic                  rsp_zero;

    logic [LEN-1:0]        aluop1;
    logic [LEN-1:0]        aluop2;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [LEN-1:0]        alu_result;
    logic                  zero;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_ctrl,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2, req1_ctrl,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  rsp_ready,
        output aluop1, aluop2, alu_ctrl,
        input  alu_result, zero
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_ctrl,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2, req1_ctrl,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        output rsp_ready,
        input  aluop1, aluop2, alu_ctrl,
        output alu_result, zero
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way arbiter; ALU_ARB_RR_EN selects round-robin with a last-grant
// flop, otherwise requester 0 has fixed priority and no flop is built.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef ALU_ARB_RR_EN
    logic last_q;

    // Reset to 1 so the first contended grant after reset goes to requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (advance) begin
            last_q <= gnt[1];
        end
    end

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_rr;
    assign unused_rr = ^{clk, rst, advance};
    assign gnt       = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one combinational ALU between two requesters and registers
// the winner's result into a tagged response slot; ALU_ARB_RR_EN enables round-robin.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int LEN = ALU_LEN
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    slot_e          state_q;
    slot_e          state_d;
    logic [1:0]     req;
    logic [1:0]     gnt;
    logic           can_accept;
    logic           accept;
    logic           id_q;
    logic           zero_q;
    logic [LEN-1:0] result_q;

    assign req        = {bus.req1_valid, bus.req0_valid};
    assign can_accept = (state_q == SLOT_EMPTY) || bus.rsp_ready;
    assign accept     = (|gnt) && can_accept;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    assign bus.req0_ready = gnt[0] && can_accept;
    assign bus.req1_ready = gnt[1] && can_accept;

    // Requester 0 passes through when nobody is granted; the ALU output is then unused.
    always_comb begin
        bus.aluop1   = bus.req0_op1;
        bus.aluop2   = bus.req0_op2;
        bus.alu_ctrl = bus.req0_ctrl;
        if (gnt[1]) begin
            bus.aluop1   = bus.req1_op1;
            bus.aluop2   = bus.req1_op2;
            bus.alu_ctrl = bus.req1_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (!accept && bus.rsp_ready) state_d = SLOT_EMPTY;
        endcase
    end

    // Payload is only written on accept, so a drain leaves the last result visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            id_q     <= 1'b0;
        end else if (accept) begin
            result_q <= bus.alu_result;
            zero_q   <= bus.zero;
            id_q     <= gnt[1];
        end
    end

    assign bus.rsp_valid  = (state_q == SLOT_FULL);
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_id     = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter with a reference model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int LEN = 32;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.LEN(LEN)) bus ();

    alu_arbiter #(.LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit             m_valid;
    bit             m_id;
    bit             m_zero;
    bit             m_last;
    logic [LEN-1:0] m_result;

    function automatic logic [LEN-1:0] alu_ref(input logic [2:0] c, input logic [LEN-1:0] a,
                                               input logic [LEN-1:0] b);
        logic [LEN-1:0] r;
        case (c)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd6:    r = a << b[4:0];
            default: r = a >> b[4:0];
        endcase
        return r;
    endfunction

    // The bench plays the shared ALU.
    assign bus.alu_result = alu_ref(bus.alu_ctrl, bus.aluop1, bus.aluop2);
    assign bus.zero       = (bus.alu_result == '0);

    function automatic void model_reset();
        m_valid  = 1'b0;
        m_id     = 1'b0;
        m_zero   = 1'b0;
        m_result = '0;
        m_last   = 1'b1;
    endfunction

    function automatic int m_winner();
        if (bus.req0_valid && bus.req1_valid) return (RR && !m_last) ? 1 : 0;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    function automatic bit m_accept(input int w);
        return (w >= 0) && (!m_valid || bus.rsp_ready);
    endfunction

    function automatic void model_update(input int w, input bit acc);
        if (acc) begin
            m_result = (w == 1) ? alu_ref(bus.req1_ctrl, bus.req1_op1, bus.req1_op2)
                                : alu_ref(bus.req0_ctrl, bus.req0_op1, bus.req0_op2);
            m_zero   = (m_result == '0);
            m_id     = (w == 1);
            m_valid  = 1'b1;
            m_last   = (w == 1);
        end else if (bus.rsp_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic drive(input bit v0, input logic [2:0] c0, input logic [LEN-1:0] a0,
                         input logic [LEN-1:0] b0, input bit v1, input logic [2:0] c1,
                         input logic [LEN-1:0] a1, input logic [LEN-1:0] b1, input bit rr);
        bus.req0_valid = v0; bus.req0_ctrl = c0; bus.req0_op1 = a0; bus.req0_op2 = b0;
        bus.req1_valid = v1; bus.req1_ctrl = c1; bus.req1_op1 = a1; bus.req1_op2 = b1;
        bus.rsp_ready  = rr;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_result !== '0) begin failures++; $display("FAIL reset_result got=%0h exp=0", bus.rsp_result); end
        checks++; if (bus.rsp_zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%0b exp=0", bus.rsp_zero); end
        checks++; if (bus.rsp_id !== 1'b0) begin failures++; $display("FAIL reset_id got=%0b exp=0", bus.rsp_id); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        int w; bit acc;
        @(negedge clk);
        drive(1, ALU_ADD, 5, 7, 0, 0, 0, 0, 1);
        #1; w = m_winner(); acc = m_accept(w);
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL add_ready got=%0b%0b exp=01", bus.req1_ready, bus.req0_ready); end
        @(posedge clk); model_update(w, acc); #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0) begin failures++; $display("FAIL add_valid_id got=%0b/%0b exp=1/0", bus.rsp_valid, bus.rsp_id); end
        checks++; if (bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0) begin failures++; $display("FAIL add_result got=%0d/%0b exp=12/0", bus.rsp_result, bus.rsp_zero); end
    endtask

    task automatic test_sub_zero();
        int w; bit acc;
        @(negedge clk);
        drive(0, 0, 0, 0, 1, ALU_SUB, 9, 9, 1);
        #1; w = m_winner(); acc = m_accept(w);
        checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin failures++; $display("FAIL sub_ready got=%0b%0b exp=10", bus.req1_ready, bus.req0_ready); end
        @(posedge clk); model_update(w, acc); #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1) begin failures++; $display("FAIL sub_valid_id got=%0b/%0b exp=1/1", bus.rsp_valid, bus.rsp_id); end
        checks++; if (bus.rsp_result !== '0 || bus.rsp_zero !== 1'b1) begin failures++; $display("FAIL sub_result got=%0d/%0b exp=0/1", bus.rsp_result, bus.rsp_zero); end
    endtask

    task automatic test_contention();
        int w; bit acc;
        bit exp_ids [4];
        for (int i = 0; i < 4; i++) exp_ids[i] = RR ? i[0] : 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1);
            #1; w = m_winner(); acc = m_accept(w);
            checks++; if (bus.req0_ready !== !exp_ids[i] || bus.req1_ready !== exp_ids[i]) begin failures++; $display("FAIL contend_ready[%0d] got=%0b%0b exp_id=%0b", i, bus.req1_ready, bus.req0_ready, exp_ids[i]); end
            @(posedge clk); model_update(w, acc); #1;
            checks++; if (bus.rsp_id !== exp_ids[i]) begin failures++; $display("FAIL contend_id[%0d] got=%0b exp=%0b", i, bus.rsp_id, exp_ids[i]); end
            checks++; if (bus.rsp_result !== m_result) begin failures++; $display("FAIL contend_result[%0d] got=%0h exp=%0h", i, bus.rsp_result, m_result); end
        end
    endtask

    task automatic test_backpressure();
        int w; bit acc;
        logic [LEN-1:0] held, a, b, expr;
        held = m_result;
        a = $urandom; b = $urandom;
        expr = alu_ref(ALU_XOR, a, b);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, ALU_XOR, a, b, 0, 0, 0, 0, 0);
            #1; w = m_winner(); acc = m_accept(w);
            checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0b%0b exp=00", i, bus.req1_ready, bus.req0_ready); end
            checks++; if (bus.aluop1 !== a || bus.aluop2 !== b || bus.alu_ctrl !== 3'(ALU_XOR)) begin failures++; $display("FAIL bp_alu_drive[%0d] got=%0h,%0h exp=%0h,%0h", i, bus.aluop1, bus.aluop2, a, b); end
            @(posedge clk); model_update(w, acc); #1;
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== held) begin failures++; $display("FAIL bp_hold[%0d] got=%0b/%0h exp=1/%0h", i, bus.rsp_valid, bus.rsp_result, held); end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1; w = m_winner(); acc = m_accept(w);
        checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", bus.req0_ready); end
        @(posedge clk); model_update(w, acc); #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== expr || bus.rsp_id !== 1'b0) begin failures++; $display("FAIL bp_release_rsp got=%0b/%0h/%0b exp=1/%0h/0", bus.rsp_valid, bus.rsp_result, bus.rsp_id, expr); end
    endtask

    task automatic test_drain();
        int w; bit acc;
        logic [LEN-1:0] held;
        held = m_result;
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1; w = m_winner(); acc = m_accept(w);
        @(posedge clk); model_update(w, acc); #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== held) begin failures++; $display("FAIL drain got=%0b/%0h exp=0/%0h", bus.rsp_valid, bus.rsp_result, held); end
    endtask

    task automatic test_random();
        int w; bit acc;
        bit pend0 = 0, pend1 = 0;
        int errs = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!pend0) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_ctrl  = 3'($urandom_range(0, 7));
                bus.req0_op1   = $urandom;
                bus.req0_op2   = ($urandom_range(0, 3) == 0) ? bus.req0_op1 : $urandom;
            end
            if (!pend1) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_ctrl  = 3'($urandom_range(0, 7));
                bus.req1_op1   = $urandom;
                bus.req1_op2   = ($urandom_range(0, 3) == 0) ? bus.req1_op1 : $urandom;
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1; w = m_winner(); acc = m_accept(w);
            checks++;
            if (bus.req0_ready !== (acc && w == 0) || bus.req1_ready !== (acc && w == 1)) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_ready[%0d] got=%0b%0b exp=%0b%0b", i, bus.req1_ready, bus.req0_ready, acc && w == 1, acc && w == 0);
            end
            pend0 = bus.req0_valid && !(acc && w == 0);
            pend1 = bus.req1_valid && !(acc && w == 1);
            @(posedge clk); model_update(w, acc); #1;
            checks++;
            if (bus.rsp_valid !== m_valid || (m_valid && (bus.rsp_id !== m_id || bus.rsp_result !== m_result || bus.rsp_zero !== m_zero))) begin
                failures++; errs++;
                if (errs < 10) $display("FAIL rand_rsp[%0d] got=%0b/%0b/%0h/%0b exp=%0b/%0b/%0h/%0b", i, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero, m_valid, m_id, m_result, m_zero);
            end
        end
    endtask

    task automatic test_reset_midcycle();
        int w; bit acc;
        @(negedge clk);
        drive(1, ALU_OR, 32'h00f0, 32'h0f00, 0, 0, 0, 0, 1);
        #1; w = m_winner(); acc = m_accept(w);
        @(posedge clk); model_update(w, acc);
        #2; rst = 1'b1; #1;
        model_reset();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_result !== '0 || bus.rsp_id !== 1'b0 || bus.rsp_zero !== 1'b0) begin failures++; $display("FAIL midreset got=%0b/%0h/%0b/%0b exp=0/0/0/0", bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.rsp_zero); end
        @(negedge clk);
        rst = 1'b0;
        drive(1, ALU_ADD, 1, 2, 1, ALU_ADD, 3, 4, 1);
        #1; w = m_winner(); acc = m_accept(w);
        checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL midreset_grant got=%0b%0b exp=01", bus.req1_ready, bus.req0_ready); end
        @(posedge clk); model_update(w, acc); #1;
        checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd3) begin failures++; $display("FAIL midreset_rsp got=%0b/%0d exp=0/3", bus.rsp_id, bus.rsp_result); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub_zero();
        test_contention();
        test_backpressure();
        test_drain();
        test_random();
        test_reset_midcycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
